// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue: entry layout,
// fetch-line geometry, default depth and the reset-enable level.
package inst_queue_pkg;
   localparam int   IQ_DEPTH_DEF = 16;
   localparam int   FETCH_SLOTS  = 4;
   localparam int   FETCH_W      = 128;
   localparam logic RST_EN       = 1'b1;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } iq_entry_t;
endpackage

// File: rtl/iq_slot_align.sv
// Left-aligns the valid instructions of a fetch line starting at fetch_pc[3:2]
// and computes how many of them fit before the end of the line.
module iq_slot_align
   import inst_queue_pkg::*;
(
   input  logic [FETCH_W-1:0] i_fetch_inst,
   input  logic [63:0]        i_fetch_pc,
   input  logic [2:0]         i_fetch_cnt,
   output iq_entry_t          o_cand [FETCH_SLOTS],
   output logic [2:0]         o_n
);
   logic [2:0] w_room;

   assign w_room = 3'd4 - {1'b0, i_fetch_pc[3:2]};
   // Slots past the end of the line are dropped, so n is clipped by the room left.
   assign o_n    = (i_fetch_cnt < w_room) ? i_fetch_cnt : w_room;

   for (genvar k = 0; k < FETCH_SLOTS; k++) begin : g_slot
      logic [2:0] w_slot;
      assign w_slot         = {1'b0, i_fetch_pc[3:2]} + 3'(k);
      assign o_cand[k].inst = w_slot[2] ? 32'd0 : i_fetch_inst[32*w_slot[1:0] +: 32];
      assign o_cand[k].pc   = i_fetch_pc + 64'(4 * k);
   end
endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and the dual decoders.
// Optional perf counters are enabled with the macro YSYX22040228_IQ_PERF_EN.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH_DEF,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [127:0]  fetch_inst,
   input  logic [63:0]   fetch_pc,
   input  logic [2:0]    fetch_cnt,
   input  logic          flush,
   output logic          dec0_valid,
   output logic          dec1_valid,
   output logic [31:0]   dec0_inst,
   output logic [31:0]   dec1_inst,
   output logic [63:0]   dec0_pc,
   output logic [63:0]   dec1_pc,
   input  logic [1:0]    dec_accept
`ifdef YSYX22040228_IQ_PERF_EN
   ,
   output logic [31:0]   iq_full_cycles,
   output logic [31:0]   iq_flush_count
`endif
);
   iq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   iq_entry_t        w_cand [FETCH_SLOTS];
   logic [2:0]       w_n_raw;
   logic [2:0]       w_n;
   logic             w_enq;
   logic             w_a0;
   logic             w_a1;
   logic [1:0]       w_d;
   logic [PTR_W-1:0] w_head1;

   iq_slot_align u_align (
      .i_fetch_inst (fetch_inst),
      .i_fetch_pc   (fetch_pc),
      .i_fetch_cnt  (fetch_cnt),
      .o_cand       (w_cand),
      .o_n          (w_n_raw)
   );

   // Readiness looks at the current count only; a same-cycle dequeue is not credited.
   assign fetch_ready = r_count <= (PTR_W+1)'(DEPTH - 4);
   assign w_enq       = fetch_valid && fetch_ready && !flush;
   assign w_n         = w_enq ? w_n_raw : 3'd0;

   assign dec0_valid  = r_count != '0;
   assign dec1_valid  = r_count >= (PTR_W+1)'(2);
   assign w_a0        = dec_accept[0] && dec0_valid;
   assign w_a1        = dec_accept[1] && dec1_valid && w_a0;
   assign w_d         = {1'b0, w_a0} + {1'b0, w_a1};
   assign w_head1     = r_head + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst == RST_EN || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_d);
         r_tail  <= r_tail + PTR_W'(w_n);
         r_count <= r_count + (PTR_W+1)'(w_n) - (PTR_W+1)'(w_d);
      end
   end

   // Storage is data only; stale contents are hidden by the valid gating below.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_SLOTS; i++) begin
         if (3'(i) < w_n) r_mem[r_tail + PTR_W'(i)] <= w_cand[i];
      end
   end

   assign dec0_inst = dec0_valid ? r_mem[r_head].inst  : 32'd0;
   assign dec0_pc   = dec0_valid ? r_mem[r_head].pc    : 64'd0;
   assign dec1_inst = dec1_valid ? r_mem[w_head1].inst : 32'd0;
   assign dec1_pc   = dec1_valid ? r_mem[w_head1].pc   : 64'd0;

`ifdef YSYX22040228_IQ_PERF_EN
   logic [31:0] r_full_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (rst == RST_EN) begin
         r_full_cycles <= '0;
         r_flush_count <= '0;
      end else begin
         if (fetch_valid && !fetch_ready && r_full_cycles != 32'hFFFF_FFFF)
            r_full_cycles <= r_full_cycles + 32'd1;
         if (flush && r_flush_count != 32'hFFFF_FFFF)
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign iq_full_cycles = r_full_cycles;
   assign iq_flush_count = r_flush_count;
`endif
endmodule
